// File: rtl/accel_csr_regfile.sv
// CSR register file between the AXI4-Lite CSR slave and the accelerator core.
// Optional cycle counter enabled by defining ACCEL_CSR_PERF_CNT_EN.
module accel_csr_regfile #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [31:0] BLOCK_ID   = 32'hACC0_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_wen,
  input  logic                  csr_ren,
  input  logic [ADDR_WIDTH-1:0] csr_addr,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  start_o,
  output logic                  abort_o,
  output logic [31:0]           cfg_src_o,
  output logic [31:0]           cfg_dst_o,
  output logic [LEN_WIDTH-1:0]  cfg_len_o,
  input  logic                  core_done_i,
  input  logic                  core_err_i,
  output logic                  irq_o
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_SRC    = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_DST    = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] A_LEN    = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_CYCLES = ADDR_WIDTH'(8'h14);
  localparam logic [ADDR_WIDTH-1:0] A_ID     = ADDR_WIDTH'(8'h18);

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  irq_en;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           src_q;
  logic [31:0]           dst_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] cycles_rd;

  logic wr_ctrl, wr_status, wr_cfg_ok;
  logic start_req, abort_req, start_acc, start_err;
  logic done_set, err_set, done_clr, err_clr;

  assign word_addr = {csr_addr[ADDR_WIDTH-1:2], 2'b00};

  assign wr_ctrl   = csr_wen && (word_addr == A_CTRL);
  assign wr_status = csr_wen && (word_addr == A_STATUS);
  // Job configuration is frozen while a job is running.
  assign wr_cfg_ok = csr_wen && !busy;

  assign start_req = wr_ctrl && csr_wdata[0];
  assign abort_req = wr_ctrl && csr_wdata[1];
  assign start_acc = start_req && !abort_req && !busy;
  assign start_err = start_req && !abort_req && busy;

  assign done_set = core_done_i && busy;
  assign err_set  = core_err_i || start_err;
  assign done_clr = wr_status && csr_wdata[1];
  assign err_clr  = wr_status && csr_wdata[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      start_o <= 1'b0;
      abort_o <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      start_o <= start_acc;
      abort_o <= abort_req;
      if (wr_ctrl) irq_en <= csr_wdata[2];

      if (abort_req || core_err_i)  busy <= 1'b0;
      else if (start_acc)           busy <= 1'b1;
      else if (done_set)            busy <= 1'b0;

      // Hardware set takes priority over a same-cycle W1C clear.
      done  <= done_set || (done && !done_clr);
      err   <= err_set  || (err && !err_clr);
      irq_o <= irq_en && (done || err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (wr_cfg_ok) begin
      if (word_addr == A_SRC) src_q <= csr_wdata[31:0];
      if (word_addr == A_DST) dst_q <= csr_wdata[31:0];
      if (word_addr == A_LEN) len_q <= csr_wdata[LEN_WIDTH-1:0];
    end
  end

`ifdef ACCEL_CSR_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cycles_q <= '0;
    else if (start_acc)                  cycles_q <= '0;
    else if (busy && (cycles_q != '1))   cycles_q <= cycles_q + 1'b1;
  end

  assign cycles_rd = DATA_WIDTH'(cycles_q);
`else
  assign cycles_rd = '0;
`endif

  assign cfg_src_o = src_q;
  assign cfg_dst_o = dst_q;
  assign cfg_len_o = len_q;

  // Zero-latency read mux; csr_ren is not needed since reads have no side effects.
  always_comb begin
    csr_rdata = '0;
    case (word_addr)
      A_CTRL:   csr_rdata = DATA_WIDTH'({irq_en, 2'b00});
      A_STATUS: csr_rdata = DATA_WIDTH'({err, done, busy});
      A_SRC:    csr_rdata = DATA_WIDTH'(src_q);
      A_DST:    csr_rdata = DATA_WIDTH'(dst_q);
      A_LEN:    csr_rdata = DATA_WIDTH'(len_q);
      A_CYCLES: csr_rdata = cycles_rd;
      A_ID:     csr_rdata = DATA_WIDTH'(BLOCK_ID);
      default:  csr_rdata = '0;
    endcase
  end

  logic unused_ren;
  assign unused_ren = csr_ren;

endmodule

// File: tb/tb_accel_csr_regfile.sv
// Directed testbench for accel_csr_regfile using immediate assertions.
module tb_accel_csr_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_wen;
  logic        csr_ren;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        start_o;
  logic        abort_o;
  logic [31:0] cfg_src_o;
  logic [31:0] cfg_dst_o;
  logic [15:0] cfg_len_o;
  logic        core_done_i;
  logic        core_err_i;
  logic        irq_o;

  int n_checks = 0;
  int n_fails  = 0;

  accel_csr_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_wen     (csr_wen),
    .csr_ren     (csr_ren),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .start_o     (start_o),
    .abort_o     (abort_o),
    .cfg_src_o   (cfg_src_o),
    .cfg_dst_o   (cfg_dst_o),
    .cfg_len_o   (cfg_len_o),
    .core_done_i (core_done_i),
    .core_err_i  (core_err_i),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    csr_wen   = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    cyc();
    csr_wen   = 1'b0;
    csr_wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    csr_addr = a;
    csr_ren  = 1'b1;
    #1;
    chk(tag, csr_rdata, exp);
    csr_ren  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; csr_wen = 1'b0; csr_ren = 1'b0; csr_addr = '0; csr_wdata = '0;
    core_done_i = 1'b0; core_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Reset state
    chk("rst_start", 32'(start_o), 32'h0);
    chk("rst_abort", 32'(abort_o), 32'h0);
    chk("rst_irq",   32'(irq_o),   32'h0);
    chk("rst_src",   cfg_src_o,    32'h0);
    chk("rst_len",   32'(cfg_len_o), 32'h0);
    rst_n = 1'b1;
    cyc();
    rd_chk("rd_id",     8'h18, 32'hACC0_0001);
    rd_chk("rd_status", 8'h04, 32'h0);
    rd_chk("rd_ctrl",   8'h00, 32'h0);
    rd_chk("rd_unmap",  8'h1C, 32'h0);
    rd_chk("rd_id_unaligned", 8'h1B, 32'hACC0_0001);

    // Idle config writes, LEN upper bits, RO ID
    wr(8'h10, 32'hFFFF_FFFF);
    rd_chk("len_upper", 8'h10, 32'h0000_FFFF);
    wr(8'h18, 32'h0);
    rd_chk("id_ro", 8'h18, 32'hACC0_0001);
    wr(8'h08, 32'h0000_1000);
    wr(8'h0C, 32'h0000_2000);
    wr(8'h10, 32'h0000_0040);
    rd_chk("rd_src", 8'h08, 32'h0000_1000);
    rd_chk("rd_dst", 8'h0C, 32'h0000_2000);

    // Start with IRQ_EN
    wr(8'h00, 32'h5);
    chk("start_pulse", 32'(start_o), 32'h1);
    rd_chk("busy_set", 8'h04, 32'h1);
    chk("cfg_len", 32'(cfg_len_o), 32'h40);
    cyc();
    chk("start_once", 32'(start_o), 32'h0);
    rd_chk("ctrl_irqen", 8'h00, 32'h4);

    core_done_i = 1'b1; cyc(); core_done_i = 1'b0;
    rd_chk("done_status", 8'h04, 32'h2);
    rd_chk("done_status_again", 8'h04, 32'h2);
    cyc();
    chk("irq_on", 32'(irq_o), 32'h1);
    wr(8'h04, 32'h2);
    rd_chk("w1c_done", 8'h04, 32'h0);
    cyc();
    chk("irq_off", 32'(irq_o), 32'h0);

    // Writes while busy
    wr(8'h00, 32'h1);
    chk("start2", 32'(start_o), 32'h1);
    wr(8'h08, 32'h0000_DEAD);
    rd_chk("src_frozen", 8'h08, 32'h0000_1000);
    chk("cfg_src_frozen", cfg_src_o, 32'h0000_1000);
    wr(8'h00, 32'h1);
    chk("start_busy_nopulse", 32'(start_o), 32'h0);
    rd_chk("start_busy_err", 8'h04, 32'h5);
    wr(8'h04, 32'h4);
    rd_chk("w1c_err", 8'h04, 32'h1);

    // Done set collides with W1C of DONE
    core_done_i = 1'b1;
    wr(8'h04, 32'h2);
    core_done_i = 1'b0;
    rd_chk("set_wins", 8'h04, 32'h2);

    // Abort wins over start
    wr(8'h00, 32'h1);
    chk("start3", 32'(start_o), 32'h1);
    wr(8'h00, 32'h3);
    chk("abort_pulse", 32'(abort_o), 32'h1);
    chk("abort_nostart", 32'(start_o), 32'h0);
    rd_chk("abort_status", 8'h04, 32'h2);
    cyc();
    chk("abort_once", 32'(abort_o), 32'h0);
    wr(8'h00, 32'h2);
    chk("abort_idle", 32'(abort_o), 32'h1);

    // Async reset mid-job
    wr(8'h00, 32'h1);
    chk("start4", 32'(start_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_start", 32'(start_o), 32'h0);
    chk("async_src", cfg_src_o, 32'h0);
    rd_chk("async_status", 8'h04, 32'h0);
    #1 rst_n = 1'b1;
    cyc();

    // Cycle counter
    wr(8'h00, 32'h1);
    repeat (99) cyc();
    core_done_i = 1'b1; cyc(); core_done_i = 1'b0;
`ifdef ACCEL_CSR_PERF_CNT_EN
    rd_chk("cycles", 8'h14, 32'd100);
`else
    rd_chk("cycles", 8'h14, 32'd0);
`endif
    rd_chk("cnt_status", 8'h04, 32'h2);
    cyc();
`ifdef ACCEL_CSR_PERF_CNT_EN
    rd_chk("cycles_hold", 8'h14, 32'd100);
`else
    rd_chk("cycles_hold", 8'h14, 32'd0);
`endif

    // Idle done ignored; error sets ERR anytime; IRQ from ERR
    wr(8'h04, 32'h2);
    core_done_i = 1'b1; cyc(); core_done_i = 1'b0;
    rd_chk("idle_done_ignored", 8'h04, 32'h0);
    core_err_i = 1'b1; cyc(); core_err_i = 1'b0;
    rd_chk("idle_err", 8'h04, 32'h4);
    wr(8'h00, 32'h4);
    cyc();
    chk("irq_err", 32'(irq_o), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
